// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Fetches over a req/ack port with at most one request in flight, applies
// decode-side redirects, and honours stall/flush from decode.
//
// state | meaning
// IDLE  | first cycle out of reset, no request yet
// FETCH | request outstanding at PC, waiting for ack
// HOLD  | word returned but decode could not take it; parked in r_hold
// KILL  | redirect arrived mid-fetch; drain the stale ack, then go to r_redir_pc
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_pc_write_enable,
    input  logic        i_ifid_write_enable,
    input  logic        i_ifid_flush,
    input  logic        i_branch,
    input  logic        i_jump,
    input  logic [31:0] i_branch_dest,
    input  logic [31:0] i_jump_dest,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc,
    output logic        o_valid
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] KILL  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_redir_pc;
    logic [31:0] r_hold;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;
    logic        r_valid;

    logic        w_redir;
    logic [31:0] w_target;
    logic        w_avail;
    logic        w_take;
    logic [31:0] w_word;

    assign w_redir  = (i_branch | i_jump) & i_pc_write_enable;
    assign w_target = i_branch ? i_branch_dest : i_jump_dest;
    assign w_avail  = ((r_state == FETCH) & i_imem_ack) | (r_state == HOLD);
    // A word is only consumed when the PC may advance past it; otherwise the
    // same address would be fetched twice. With the PC frozen the word parks in HOLD.
    assign w_take   = w_avail & i_ifid_write_enable & ~i_ifid_flush & ~w_redir
                      & i_pc_write_enable;
    assign w_word   = (r_state == HOLD) ? r_hold : i_imem_rdata;

    assign o_imem_req    = (r_state == FETCH) | (r_state == KILL);
    assign o_imem_addr   = r_pc;
    assign o_instruction = r_instr;
    assign o_pc          = r_pc_out;
    assign o_valid       = r_valid;

    // Fetch FSM and PC update
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_redir_pc <= RESET_PC;
            r_hold     <= NOP_INSTR;
        end else begin
            case (r_state)
                IDLE: r_state <= FETCH;
                FETCH: begin
                    if (w_redir && i_imem_ack) begin
                        r_pc <= w_target;
                    end else if (w_redir) begin
                        r_state    <= KILL;
                        r_redir_pc <= w_target;
                    end else if (w_take) begin
                        r_pc <= r_pc + 32'd4;
                    end else if (i_imem_ack) begin
                        r_state <= HOLD;
                        r_hold  <= i_imem_rdata;
                    end
                end
                HOLD: begin
                    if (w_redir) begin
                        r_state <= FETCH;
                        r_pc    <= w_target;
                    end else if (w_take) begin
                        r_state <= FETCH;
                        r_pc    <= r_pc + 32'd4;
                    end
                end
                KILL: begin
                    if (i_imem_ack) begin
                        r_state <= FETCH;
                        r_pc    <= w_redir ? w_target : r_redir_pc;
                    end else if (w_redir) begin
                        r_redir_pc <= w_target;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // IF/ID pipeline register: flush, then stall, then load or bubble
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_instr  <= NOP_INSTR;
            r_pc_out <= 32'h0000_0000;
            r_valid  <= 1'b0;
        end else if (i_ifid_flush) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (!i_ifid_write_enable) begin
            r_instr  <= r_instr;
        end else if (w_take) begin
            r_instr  <= w_word;
            r_pc_out <= r_pc;
            r_valid  <= 1'b1;
        end else begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. Memory word for address A is A ^ KEY unless
// corrupt is set, which lets the bench tell a held/dropped word from a fresh one.
module tb_if_stage;

    localparam logic [31:0] KEY = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst, pc_we, ifid_we, flush, branch, jump, ack, corrupt;
    logic [31:0] bdest, jdest;
    logic        req, valid;
    logic [31:0] addr, rdata, instr, pc_o;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign rdata = corrupt ? 32'hDEAD_BEEF : (addr ^ KEY);

    if_stage dut (
        .i_clock(clk), .i_reset(rst), .i_pc_write_enable(pc_we),
        .i_ifid_write_enable(ifid_we), .i_ifid_flush(flush),
        .i_branch(branch), .i_jump(jump), .i_branch_dest(bdest), .i_jump_dest(jdest),
        .o_imem_req(req), .o_imem_addr(addr), .i_imem_ack(ack), .i_imem_rdata(rdata),
        .o_instruction(instr), .o_pc(pc_o), .o_valid(valid)
    );

    task automatic test_reset();
        rst = 1; pc_we = 1; ifid_we = 1; flush = 0; branch = 0; jump = 0;
        bdest = 0; jdest = 0; ack = 0; corrupt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b want 0", req); end
        checks++; if (addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", addr); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", instr); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", pc_o); end
        rst = 0;
        ack = 1;
    endtask

    task automatic test_stream();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (req !== 1'b1 || addr !== 32'(4 * k)) begin
                errors++; $display("FAIL stream_addr k=%0d got req=%0b addr=%h want 1 %h", k, req, addr, 32'(4 * k));
            end
            if (k > 0) begin
                checks++; if (valid !== 1'b1 || pc_o !== 32'(4 * (k - 1)) || instr !== (32'(4 * (k - 1)) ^ KEY)) begin
                    errors++; $display("FAIL stream_ifid k=%0d got v=%0b pc=%h ins=%h want 1 %h %h",
                                       k, valid, pc_o, instr, 32'(4 * (k - 1)), 32'(4 * (k - 1)) ^ KEY);
                end
            end
        end
    endtask

    task automatic test_wait_ack();
        ack = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (req !== 1'b1 || addr !== 32'd12 || valid !== 1'b0) begin
                errors++; $display("FAIL wait_bubble k=%0d got req=%0b addr=%h v=%0b want 1 0000000c 0", k, req, addr, valid);
            end
        end
        ack = 1;
        @(negedge clk);
        checks++; if (addr !== 32'd16 || valid !== 1'b1 || pc_o !== 32'd12 || instr !== (32'd12 ^ KEY)) begin
            errors++; $display("FAIL wait_word got addr=%h v=%0b pc=%h ins=%h want 10 1 0c %h", addr, valid, pc_o, instr, 32'd12 ^ KEY);
        end
    endtask

    task automatic test_stall();
        ifid_we = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (req !== 1'b0 || addr !== 32'd16 || pc_o !== 32'd12 || valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold k=%0d got req=%0b addr=%h pc=%h v=%0b want 0 10 0c 1", k, req, addr, pc_o, valid);
            end
            corrupt = 1;
        end
        ifid_we = 1;
        @(negedge clk);
        corrupt = 0;
        checks++; if (req !== 1'b1 || addr !== 32'd20 || pc_o !== 32'd16 || instr !== (32'd16 ^ KEY) || valid !== 1'b1) begin
            errors++; $display("FAIL stall_release got req=%0b addr=%h pc=%h ins=%h v=%0b want 1 14 10 %h 1",
                               req, addr, pc_o, instr, valid, 32'd16 ^ KEY);
        end
    endtask

    task automatic test_kill();
        ack = 0; branch = 1; flush = 1; bdest = 32'h100;
        @(negedge clk);
        checks++; if (req !== 1'b1 || addr !== 32'd20 || valid !== 1'b0) begin
            errors++; $display("FAIL kill_enter got req=%0b addr=%h v=%0b want 1 14 0", req, addr, valid);
        end
        branch = 0; flush = 0;
        @(negedge clk);
        checks++; if (req !== 1'b1 || addr !== 32'd20) begin
            errors++; $display("FAIL kill_wait got req=%0b addr=%h want 1 14", req, addr);
        end
        ack = 1; corrupt = 1;
        @(negedge clk);
        corrupt = 0;
        checks++; if (req !== 1'b1 || addr !== 32'h100 || valid !== 1'b0) begin
            errors++; $display("FAIL kill_drop got req=%0b addr=%h v=%0b want 1 100 0", req, addr, valid);
        end
        @(negedge clk);
        checks++; if (addr !== 32'h104 || pc_o !== 32'h100 || instr !== (32'h100 ^ KEY) || valid !== 1'b1) begin
            errors++; $display("FAIL kill_target got addr=%h pc=%h ins=%h v=%0b want 104 100 %h 1", addr, pc_o, instr, valid, 32'h100 ^ KEY);
        end
    endtask

    task automatic test_priority();
        branch = 1; jump = 1; bdest = 32'h200; jdest = 32'h300;
        @(negedge clk);
        checks++; if (addr !== 32'h200 || valid !== 1'b0) begin
            errors++; $display("FAIL prio_branch got addr=%h v=%0b want 200 0", addr, valid);
        end
        bdest = 32'h400; jdest = 32'h500; pc_we = 0;
        @(negedge clk);
        checks++; if (addr !== 32'h200 || req !== 1'b0) begin
            errors++; $display("FAIL prio_blocked got addr=%h req=%0b want 200 0", addr, req);
        end
        branch = 0; jump = 0; pc_we = 1;
        @(negedge clk);
        checks++; if (addr !== 32'h204 || pc_o !== 32'h200 || valid !== 1'b1 || instr !== (32'h200 ^ KEY)) begin
            errors++; $display("FAIL prio_release got addr=%h pc=%h v=%0b ins=%h want 204 200 1 %h", addr, pc_o, valid, instr, 32'h200 ^ KEY);
        end
    endtask

    task automatic test_wrap_and_reset();
        jump = 1; jdest = 32'hFFFF_FFFC;
        @(negedge clk);
        jump = 0;
        checks++; if (addr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_jump got addr=%h want fffffffc", addr);
        end
        @(negedge clk);
        checks++; if (addr !== 32'h0 || pc_o !== 32'hFFFF_FFFC || valid !== 1'b1) begin
            errors++; $display("FAIL wrap_next got addr=%h pc=%h v=%0b want 0 fffffffc 1", addr, pc_o, valid);
        end
        ack = 0; branch = 1; bdest = 32'h40;
        @(negedge clk);
        branch = 0;
        checks++; if (req !== 1'b1 || addr !== 32'h0) begin
            errors++; $display("FAIL rkill_enter got req=%0b addr=%h want 1 0", req, addr);
        end
        rst = 1;
        @(negedge clk);
        checks++; if (req !== 1'b0 || addr !== 32'h0 || valid !== 1'b0 || instr !== 32'h0 || pc_o !== 32'h0) begin
            errors++; $display("FAIL rkill_reset got req=%0b addr=%h v=%0b ins=%h pc=%h want 0 0 0 0 0", req, addr, valid, instr, pc_o);
        end
        rst = 0;
        @(negedge clk);
        checks++; if (req !== 1'b1 || addr !== 32'h0) begin
            errors++; $display("FAIL rkill_refetch got req=%0b addr=%h want 1 0", req, addr);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_wait_ack();
        test_stall();
        test_kill();
        test_priority();
        test_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
